// File: rtl/gpr_file_mp_if.sv
// -----------------------------------------------------------------------------
// gpr_file_mp_if
//   Bus bundle between the decode/writeback side and the multi-port register
//   file gpr_file_mp. Clock and reset are not part of the bundle.
//
//   Parameters
//     DATA_W  entry width in bits
//     ADDR_W  address width
//     NUM_RD  number of read ports
//
//   Signals (direction as seen from the register file, modport slave)
//     init_done  out  clear sequence finished
//     we         in   writeback write enable
//     waddr      in   writeback address
//     wdata      in   writeback data
//     rsv_en     in   reserve (mark pending) rsv_addr
//     rsv_addr   in   destination being reserved
//     flush      in   drop every reservation
//     re         in   per-port read enable
//     raddr      in   packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//     rdata      out  packed read data, port i at [i*DATA_W +: DATA_W]
//     rbusy      out  per-port operand-not-ready flag
// -----------------------------------------------------------------------------
interface gpr_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) ();

  logic                     init_done;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     flush;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;

  // Decode / writeback side
  modport master (
    input  init_done,
    input  rdata,
    input  rbusy,
    output we,
    output waddr,
    output wdata,
    output rsv_en,
    output rsv_addr,
    output flush,
    output re,
    output raddr
  );

  // Register file side
  modport slave (
    output init_done,
    output rdata,
    output rbusy,
    input  we,
    input  waddr,
    input  wdata,
    input  rsv_en,
    input  rsv_addr,
    input  flush,
    input  re,
    input  raddr
  );

endinterface

// File: rtl/gpr_file_mp.sv
// -----------------------------------------------------------------------------
// gpr_file_mp
//   Multi-read-port general-purpose register file for the decode stage with a
//   per-entry pending-write scoreboard. After reset the array is swept to zero
//   one entry per cycle (INIT); normal operation (RUN) starts once the last
//   entry has been cleared.
//
//   Optional feature macro: GPR_BYPASS_EN
//     defined   : a same-cycle writeback is forwarded to matching read ports
//                 (data = wdata, busy = 0)
//     undefined : reads see registered state only
//
//   Parameters
//     DATA_W    entry width
//     ADDR_W    address width, DEPTH = 2**ADDR_W
//     NUM_RD    number of read ports (1..4)
//     ZERO_REG  1: entry 0 reads zero, is never written, never pending
//
//   Ports
//     clk   in  clock, rising edge
//     rst   in  asynchronous active-high reset, restarts the clear sweep
//     bus   gpr_file_mp_if.slave (see interface header)
// -----------------------------------------------------------------------------
module gpr_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic          clk,
  input  logic          rst,
  gpr_file_mp_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
  localparam logic [DEPTH-1:0]  ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                   state_r;
  state_t                   state_nxt_s;
  logic [ADDR_W-1:0]        cnt_r;
  logic [ADDR_W-1:0]        cnt_nxt_s;
  logic                     init_done_r;

  logic [DATA_W-1:0]        mem_r [DEPTH];
  logic [DEPTH-1:0]         pend_r;
  logic [DEPTH-1:0]         pend_nxt_s;

  logic                     run_s;
  logic                     wr_ok_s;
  logic                     rsv_ok_s;
  logic [DEPTH-1:0]         wr_clr_mask_s;
  logic [DEPTH-1:0]         rsv_set_mask_s;

  logic [ADDR_W-1:0]        ra_s [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rdata_s;
  logic [NUM_RD-1:0]        rbusy_s;

  // Entry 0 is hard-wired when ZERO_REG is set: no write, no reservation,
  // always reads zero and never busy.
  function automatic logic is_prot(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
  endfunction

  // ---------------------------------------------------------------------------
  // Control qualification
  // ---------------------------------------------------------------------------
  assign run_s    = (state_r == ST_RUN);
  assign wr_ok_s  = run_s && bus.we     && !is_prot(bus.waddr);
  assign rsv_ok_s = run_s && bus.rsv_en && !is_prot(bus.rsv_addr);

  // One-hot masks of the scoreboard bit released by writeback and set by issue
  assign wr_clr_mask_s  = wr_ok_s  ? (ONE_HOT0 << bus.waddr)    : {DEPTH{1'b0}};
  assign rsv_set_mask_s = rsv_ok_s ? (ONE_HOT0 << bus.rsv_addr) : {DEPTH{1'b0}};

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State, sweep counter and init_done flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_INIT;
      cnt_r       <= {ADDR_W{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      init_done_r <= (state_nxt_s == ST_RUN);
    end
  end

  // Next-state logic: INIT sweeps every entry once, then RUN until reset
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        cnt_nxt_s = cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (cnt_r == CNT_LAST) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_INIT;
        end
      end
      ST_RUN: begin
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = {ADDR_W{1'b0}};
      end
      default: begin
        state_nxt_s = ST_INIT;
        cnt_nxt_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------

  // Data array: zero sweep while INIT, writeback while RUN. No reset on the
  // array itself; contents are defined only once the sweep has completed.
  always_ff @(posedge clk) begin
    if (state_r == ST_INIT) begin
      mem_r[cnt_r] <= {DATA_W{1'b0}};
    end else if (wr_ok_s) begin
      mem_r[bus.waddr] <= bus.wdata;
    end
  end

  // Scoreboard update: flush beats everything; otherwise reserve is applied
  // after the writeback release so a same-address pair ends up pending.
  always_comb begin
    pend_nxt_s = pend_r;
    if (!run_s) begin
      pend_nxt_s = pend_r;
    end else if (bus.flush) begin
      pend_nxt_s = {DEPTH{1'b0}};
    end else begin
      pend_nxt_s = (pend_r & ~wr_clr_mask_s) | rsv_set_mask_s;
    end
  end

  // Scoreboard register, cleared asynchronously by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= {DEPTH{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_RD; g++) begin : g_ra
    assign ra_s[g] = bus.raddr[g*ADDR_W +: ADDR_W];
  end

  // Combinational read: INIT masks data and reports everything busy; in RUN
  // each port is independent and optionally forwards the current writeback.
  always_comb begin
    rdata_s = {(NUM_RD*DATA_W){1'b0}};
    rbusy_s = {NUM_RD{1'b0}};
    if (!run_s) begin
      rdata_s = {(NUM_RD*DATA_W){1'b0}};
      rbusy_s = {NUM_RD{1'b1}};
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (!bus.re[i] || is_prot(ra_s[i])) begin
          rdata_s[i*DATA_W +: DATA_W] = {DATA_W{1'b0}};
          rbusy_s[i]                  = 1'b0;
        end else begin
`ifdef GPR_BYPASS_EN
          if (wr_ok_s && (ra_s[i] == bus.waddr)) begin
            rdata_s[i*DATA_W +: DATA_W] = bus.wdata;
            rbusy_s[i]                  = 1'b0;
          end else begin
            rdata_s[i*DATA_W +: DATA_W] = mem_r[ra_s[i]];
            rbusy_s[i]                  = pend_r[ra_s[i]];
          end
`else
          rdata_s[i*DATA_W +: DATA_W] = mem_r[ra_s[i]];
          rbusy_s[i]                  = pend_r[ra_s[i]];
`endif
        end
      end
    end
  end

  assign bus.rdata     = rdata_s;
  assign bus.rbusy     = rbusy_s;
  assign bus.init_done = init_done_r;

endmodule
